// File: rtl/mem_map_pkg.sv
// Shared memory-map constants and the DMA state encoding.
// The memory module imports the same constants so that both sides agree on
// where RAM, tilemap, framebuffer and I/O begin.
package mem_map_pkg;

    localparam logic [15:0] TILEMAP_START     = 16'hC000;
    localparam logic [15:0] FRAMEBUFFER_START = 16'hE000;
    localparam logic [15:0] IO_START          = 16'hF000;
    localparam logic [15:0] PS2_REG           = 16'hF000;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } dma_state_t;

endpackage

// File: rtl/dma_skid_buf.sv
// One-entry skid buffer and the memory write-port select.
// A CPU write always wins the write port. If that happens while a DMA read is
// returning, the returning word is parked here and written out on the next
// free write slot.
//   clk, rst_n           clock, asynchronous active-low reset
//   cpu_wen/waddr/wdata  CPU write request (highest priority)
//   rd_inflight          a DMA read returns on mem_rdata this cycle
//   mem_rdata            memory registered read data
//   wr_ptr               current DMA destination address
//   buf_valid            buffer holds a word waiting to be written
//   dma_wr               a DMA word is written this cycle
//   mem_wen/waddr/wdata  memory write port
module dma_skid_buf #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_wen,
    input  logic [ADDR_W-1:0] cpu_waddr,
    input  logic [ADDR_W-1:0] cpu_wdata,
    input  logic              rd_inflight,
    input  logic [ADDR_W-1:0] mem_rdata,
    input  logic [ADDR_W-1:0] wr_ptr,
    output logic              buf_valid,
    output logic              dma_wr,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [ADDR_W-1:0] mem_wdata
);

    logic [ADDR_W-1:0] buf_data;

    // Capture/drain. The issue logic never lets a read return while the
    // buffer is full, so capture and drain never coincide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_valid <= 1'b0;
            buf_data  <= '0;
        end else if (rd_inflight && cpu_wen) begin
            buf_valid <= 1'b1;
            buf_data  <= mem_rdata;
        end else if (buf_valid && !cpu_wen) begin
            buf_valid <= 1'b0;
        end
    end

    always_comb begin
        mem_wen   = 1'b0;
        mem_waddr = '0;
        mem_wdata = '0;
        dma_wr    = 1'b0;
        if (cpu_wen) begin
            mem_wen   = 1'b1;
            mem_waddr = cpu_waddr;
            mem_wdata = cpu_wdata;
        end else if (buf_valid) begin
            mem_wen   = 1'b1;
            mem_waddr = wr_ptr;
            mem_wdata = buf_data;
            dma_wr    = 1'b1;
        end else if (rd_inflight) begin
            mem_wen   = 1'b1;
            mem_waddr = wr_ptr;
            mem_wdata = mem_rdata;
            dma_wr    = 1'b1;
        end
    end

endmodule

// File: rtl/vram_dma.sv
// Block-copy engine between the CPU data port and memory port 1.
// Copies len words from src to dst in ascending order using only the read and
// write slots the CPU leaves idle; the CPU is never stalled.
//   clk, rst_n              clock, asynchronous active-low reset
//   start, src, dst, len    copy request (sampled when idle)
//   busy, done, err         copy status; done/err are one-cycle pulses
//   cpu_ren/raddr/rdata     CPU read port (rdata valid 1 cycle later, then held)
//   cpu_wen/waddr/wdata     CPU write port
//   mem_ren/raddr/rdata     memory read port (registered, 1-cycle latency)
//   mem_wen/waddr/wdata     memory write port
module vram_dma #(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] IO_START = 16'hF000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] src,
    input  logic [ADDR_W-1:0] dst,
    input  logic [ADDR_W-1:0] len,
    output logic              busy,
    output logic              done,
    output logic              err,
    input  logic              cpu_ren,
    input  logic [ADDR_W-1:0] cpu_raddr,
    output logic [ADDR_W-1:0] cpu_rdata,
    input  logic              cpu_wen,
    input  logic [ADDR_W-1:0] cpu_waddr,
    input  logic [ADDR_W-1:0] cpu_wdata,
    output logic              mem_ren,
    output logic [ADDR_W-1:0] mem_raddr,
    input  logic [ADDR_W-1:0] mem_rdata,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [ADDR_W-1:0] mem_wdata
);

    import mem_map_pkg::*;

    localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

    dma_state_t        state, state_nxt;
    logic [ADDR_W-1:0] rd_ptr, wr_ptr, rd_left, wr_left;
    logic [ADDR_W-1:0] rd_hold;
    logic              rd_inflight, cpu_rd_d;
    logic              buf_valid, dma_wr, dma_issue;
    logic              load, done_nxt, err_nxt, range_ok;
    logic [ADDR_W:0]   src_end, dst_end;

    // One bit wider so that an end address past the top cannot wrap into range.
    assign src_end  = {1'b0, src} + {1'b0, len};
    assign dst_end  = {1'b0, dst} + {1'b0, len};
    assign range_ok = (src_end <= {1'b0, IO_START}) && (dst_end <= {1'b0, IO_START});

    // A read may not be issued while a returning word would have nowhere to
    // go: the buffer is full, or it is about to fill this cycle.
    assign dma_issue = (state == RUN) && !cpu_ren && (rd_left != '0) &&
                       !buf_valid && !(rd_inflight && cpu_wen);

    assign busy      = (state == RUN);
    assign mem_ren   = cpu_ren || dma_issue;
    assign mem_raddr = cpu_ren ? cpu_raddr : rd_ptr;
    assign cpu_rdata = cpu_rd_d ? mem_rdata : rd_hold;

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (!range_ok) begin
                        err_nxt = 1'b1;
                    end else if (len == '0) begin
                        done_nxt = 1'b1;
                    end else begin
                        load      = 1'b1;
                        state_nxt = RUN;
                    end
                end
            end
            RUN: begin
                if (dma_wr && (wr_left == ONE)) begin
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done        <= 1'b0;
            err         <= 1'b0;
            rd_inflight <= 1'b0;
            cpu_rd_d    <= 1'b0;
            rd_hold     <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            rd_left     <= '0;
            wr_left     <= '0;
        end else begin
            done        <= done_nxt;
            err         <= err_nxt;
            rd_inflight <= dma_issue;
            cpu_rd_d    <= cpu_ren;
            if (cpu_rd_d) begin
                rd_hold <= mem_rdata;
            end
            if (load) begin
                rd_ptr  <= src;
                wr_ptr  <= dst;
                rd_left <= len;
                wr_left <= len;
            end else begin
                if (dma_issue) begin
                    rd_ptr  <= rd_ptr + ONE;
                    rd_left <= rd_left - ONE;
                end
                if (dma_wr) begin
                    wr_ptr  <= wr_ptr + ONE;
                    wr_left <= wr_left - ONE;
                end
            end
        end
    end

    dma_skid_buf #(.ADDR_W(ADDR_W)) u_skid (
        .clk         (clk),
        .rst_n       (rst_n),
        .cpu_wen     (cpu_wen),
        .cpu_waddr   (cpu_waddr),
        .cpu_wdata   (cpu_wdata),
        .rd_inflight (rd_inflight),
        .mem_rdata   (mem_rdata),
        .wr_ptr      (wr_ptr),
        .buf_valid   (buf_valid),
        .dma_wr      (dma_wr),
        .mem_wen     (mem_wen),
        .mem_waddr   (mem_waddr),
        .mem_wdata   (mem_wdata)
    );

endmodule

// File: tb/tb_vram_dma.sv
// Directed bench for vram_dma with a behavioural registered-read memory.
module tb_vram_dma;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] src = '0, dst = '0, len = '0;
    logic        busy, done, err;
    logic        cpu_ren = 1'b0;
    logic [15:0] cpu_raddr = '0;
    logic [15:0] cpu_rdata;
    logic        cpu_wen = 1'b0;
    logic [15:0] cpu_waddr = '0, cpu_wdata = '0;
    logic        mem_ren, mem_wen;
    logic [15:0] mem_raddr, mem_rdata, mem_waddr, mem_wdata;

    logic        tb_we = 1'b0;
    logic [15:0] tb_wa = '0, tb_wd = '0;
    logic [15:0] mem [0:65535];

    int          n_pass = 0;
    int          n_total = 0;
    logic        inv_bad = 1'b0;
    logic [15:0] tr_busy, tr_done, tr_err, tr_wen, tr_ren, tr_buf;
    logic [15:0] exp_rd;
    logic        have_rd;
    int          done_c, done_n;

    always #5 clk = ~clk;

    vram_dma dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .src       (src),
        .dst       (dst),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .cpu_ren   (cpu_ren),
        .cpu_raddr (cpu_raddr),
        .cpu_rdata (cpu_rdata),
        .cpu_wen   (cpu_wen),
        .cpu_waddr (cpu_waddr),
        .cpu_wdata (cpu_wdata),
        .mem_ren   (mem_ren),
        .mem_raddr (mem_raddr),
        .mem_rdata (mem_rdata),
        .mem_wen   (mem_wen),
        .mem_waddr (mem_waddr),
        .mem_wdata (mem_wdata)
    );

    // Memory model: registered read, independent write, bench preload port.
    always @(posedge clk) begin
        if (mem_ren) mem_rdata <= mem[mem_raddr];
        if (mem_wen) mem[mem_waddr] <= mem_wdata;
        if (tb_we)   mem[tb_wa] <= tb_wd;
    end

    always @(negedge clk) begin
        if (rst_n) begin
            inv_chk: assert (!(dut.buf_valid && dut.rd_inflight)) else inv_bad = 1'b1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic poke(input logic [15:0] a, input logic [15:0] d);
        tb_we = 1'b1; tb_wa = a; tb_wd = d;
        @(posedge clk); #1;
        tb_we = 1'b0;
    endtask

    task automatic clear_tr();
        tr_busy = '0; tr_done = '0; tr_err = '0; tr_wen = '0; tr_ren = '0; tr_buf = '0;
    endtask

    task automatic record(input int c);
        tr_busy[c] = busy; tr_done[c] = done; tr_err[c] = err;
        tr_wen[c] = mem_wen; tr_ren[c] = mem_ren; tr_buf[c] = dut.buf_valid;
    endtask

    // Issues a start in the current cycle; the caller's loop then runs cycles 1..N.
    task automatic kick(input logic [15:0] s, input logic [15:0] d, input logic [15:0] l);
        @(posedge clk); #1;
        start = 1'b1; src = s; dst = d; len = l;
        @(negedge clk);
    endtask

    initial begin
        // Reset
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_status", {busy, done, err, mem_ren, mem_wen}, 0);
        check("rst_cpu_rdata", cpu_rdata, 16'h0000);

        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) poke(16'h0100 + 16'(i), 16'hA001 + 16'(i));
        for (int i = 0; i < 8; i++) poke(16'h0300 + 16'(i), 16'h3300 + 16'(i));
        for (int i = 0; i < 10; i++) poke(16'h0010 + 16'(i), 16'h5A00 + 16'(i));
        for (int i = 0; i < 6; i++) poke(16'h0400 + 16'(i), 16'h4400 + 16'(i));
        for (int i = 0; i < 6; i++) poke(16'hE200 + 16'(i), 16'h0000);

        // 1: plain 4-word copy
        kick(16'h0100, 16'hE000, 16'd4);
        check("t1_busy_c0", busy, 0);
        clear_tr();
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); #1; start = 1'b0;
            @(negedge clk); record(c);
            if (c == 2) begin
                check("t1_waddr_c2", mem_waddr, 16'hE000);
                check("t1_wdata_c2", mem_wdata, 16'hA001);
            end
        end
        check("t1_busy", tr_busy, 16'h003E);
        check("t1_ren", tr_ren, 16'h001E);
        check("t1_wen", tr_wen, 16'h003C);
        check("t1_done", tr_done, 16'h0040);
        check("t1_err", tr_err, 16'h0000);
        for (int i = 0; i < 4; i++) check("t1_data", mem[16'hE000 + 16'(i)], 16'hA001 + 16'(i));

        // 2: CPU writes in cycles 1..3 of the copy
        kick(16'h0100, 16'hE010, 16'd4);
        clear_tr();
        for (int c = 1; c <= 11; c++) begin
            @(posedge clk); #1; start = 1'b0;
            cpu_wen = (c <= 3); cpu_waddr = 16'h01FF + 16'(c); cpu_wdata = 16'h7000 + 16'(c);
            @(negedge clk); record(c);
        end
        @(posedge clk); #1; cpu_wen = 1'b0;
        check("t2_busy", tr_busy, 16'h01FE);
        check("t2_wen", tr_wen, 16'h01DE);
        check("t2_done", tr_done, 16'h0200);
        check("t2_buf", tr_buf, 16'h0018);
        for (int i = 0; i < 4; i++) check("t2_data", mem[16'hE010 + 16'(i)], 16'hA001 + 16'(i));
        for (int i = 0; i < 3; i++) check("t2_cpu_wr", mem[16'h0200 + 16'(i)], 16'h7001 + 16'(i));

        // 3: CPU reads on odd cycles during an 8-word copy
        kick(16'h0300, 16'hE100, 16'd8);
        have_rd = 1'b0; exp_rd = '0; done_c = 0; done_n = 0;
        for (int c = 1; c <= 22; c++) begin
            @(posedge clk); #1; start = 1'b0;
            cpu_ren = (c % 2 == 1) && (c <= 19);
            cpu_raddr = 16'h0010 + 16'(c >> 1);
            @(negedge clk);
            if (have_rd) check("t3_cpu_rdata", cpu_rdata, exp_rd);
            if (done) begin done_n++; done_c = c; end
            if (cpu_ren) begin exp_rd = 16'h5A00 + 16'(c >> 1); have_rd = 1'b1; end
        end
        @(posedge clk); #1; cpu_ren = 1'b0;
        check("t3_done_cycle", done_c, 18);
        check("t3_done_count", done_n, 1);
        for (int i = 0; i < 8; i++) check("t3_data", mem[16'hE100 + 16'(i)], 16'h3300 + 16'(i));

        // 4: out-of-range and zero-length requests
        kick(16'hEFFE, 16'hE000, 16'd3);
        for (int c = 1; c <= 2; c++) begin
            @(posedge clk); #1; start = 1'b0;
            @(negedge clk);
            check("t4_src_err", err, (c == 1));
            check("t4_src_quiet", {busy, done, mem_ren, mem_wen}, 0);
        end
        kick(16'h0100, 16'hEFFF, 16'd2);
        @(posedge clk); #1; start = 1'b0;
        @(negedge clk);
        check("t4_dst_err", err, 1);
        check("t4_dst_quiet", {busy, done, mem_ren, mem_wen}, 0);
        kick(16'h0100, 16'hE000, 16'd0);
        for (int c = 1; c <= 2; c++) begin
            @(posedge clk); #1; start = 1'b0;
            @(negedge clk);
            check("t4_len0_done", done, (c == 1));
            check("t4_len0_quiet", {busy, err, mem_ren, mem_wen}, 0);
        end

        // 5: reset mid-copy, then a fresh copy
        kick(16'h0400, 16'hE200, 16'd6);
        for (int c = 1; c <= 2; c++) begin
            @(posedge clk); #1; start = 1'b0;
        end
        @(posedge clk); #1; rst_n = 1'b0;
        #1;
        check("t5_rst_status", {busy, done, err, mem_ren, mem_wen}, 0);
        check("t5_rst_cpu_rdata", cpu_rdata, 16'h0000);
        check("t5_rst_addrs", {mem_raddr, mem_waddr}, 0);
        check("t5_rst_wdata", mem_wdata, 16'h0000);
        clear_tr();
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk); record(c);
        end
        check("t5_rst_wen", tr_wen, 16'h0000);
        @(posedge clk); #1; rst_n = 1'b1;
        @(negedge clk);
        check("t5_word0", mem[16'hE200], 16'h4400);
        for (int i = 1; i < 6; i++) check("t5_untouched", mem[16'hE200 + 16'(i)], 16'h0000);
        kick(16'h0400, 16'hE300, 16'd6);
        clear_tr();
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1; start = 1'b0;
            @(negedge clk); record(c);
        end
        check("t5_done", tr_done, 16'h0100);
        for (int i = 0; i < 6; i++) check("t5_data", mem[16'hE300 + 16'(i)], 16'h4400 + 16'(i));

        // 6: start while busy is ignored
        kick(16'h0100, 16'hE400, 16'd4);
        clear_tr();
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); #1;
            start = (c == 2); src = 16'hEFFE; dst = 16'h0000; len = 16'd3;
            @(negedge clk); record(c);
        end
        check("t6_busy", tr_busy, 16'h003E);
        check("t6_done", tr_done, 16'h0040);
        check("t6_err", tr_err, 16'h0000);
        for (int i = 0; i < 4; i++) check("t6_data", mem[16'hE400 + 16'(i)], 16'hA001 + 16'(i));

        check("invariant_buf_inflight", inv_bad, 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/vram_dma.md
Name: vram_dma

Overview:
- Block-copy engine that moves word ranges from RAM or tilemap into the tilemap or framebuffer, for tile uploads and screen scrolls.
- Sits between the CPU data port and the memory module's port 1, which has a registered read (1-cycle latency) and an independent write port.
- Arbitrates that port: the CPU has strict priority and never stalls; the DMA uses only idle read/write slots.

Parameters:
- IO_START, 16'hF000, first non-copyable address; no DMA source or destination word may be at or above it.
- ADDR_W, 16, address, length and data width.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request to begin a copy; ignored while busy=1
- src  in  16  first source word address, sampled on start
- dst  in  16  first destination word address, sampled on start
- len  in  16  word count, sampled on start
- busy  out  1  copy in progress
- done  out  1  one-cycle pulse: copy complete
- err  out  1  one-cycle pulse: request rejected
- cpu_ren  in  1  CPU read request
- cpu_raddr  in  16  CPU read address
- cpu_rdata  out  16  CPU read data, valid 1 cycle after cpu_ren and held until the next CPU read returns
- cpu_wen  in  1  CPU write request
- cpu_waddr  in  16  CPU write address
- cpu_wdata  in  16  CPU write data
- mem_ren  out  1  memory read enable
- mem_raddr  out  16  memory read address
- mem_rdata  in  16  memory registered read data
- mem_wen  out  1  memory write enable
- mem_waddr  out  16  memory write address
- mem_wdata  out  16  memory write data

Behaviour:
- Reset (async): state IDLE; busy, done, err, buf_valid, rd_inflight, cpu_rd_d = 0; cpu_rdata hold register = 0; pointers and counters = 0. A reset during a copy drops the in-flight read and the buffered word. No further memory access occurs.
- States:
  - IDLE: on start, check the range using 17-bit sums. If src+len > IO_START or dst+len > IO_START, pulse err next cycle and stay IDLE. Else if len == 0, pulse done next cycle and stay IDLE with no memory access. Else load rd_ptr=src, wr_ptr=dst, rd_left=len, wr_left=len and go to RUN (busy=1 from the next cycle).
  - RUN: go to IDLE when wr_left reaches 0. done pulses in the first IDLE cycle, and busy falls in the same cycle.
- Read port (combinational mux):
  - mem_ren = cpu_ren | dma_issue; mem_raddr = cpu_ren ? cpu_raddr : rd_ptr.
  - dma_issue = RUN & !cpu_ren & rd_left != 0 & !buf_valid & !(rd_inflight & cpu_wen).
  - On issue: rd_ptr++, rd_left--, rd_inflight = 1 next cycle.
- Write port:
  - If cpu_wen: CPU address and data are forwarded to memory.
  - Else if buf_valid: write buffered word to wr_ptr.
  - Else if rd_inflight: write mem_rdata directly to wr_ptr.
  - Each DMA write increments wr_ptr and decrements wr_left.
  - If rd_inflight and cpu_wen in the same cycle, capture mem_rdata into the buffer (buf_valid = 1).
  - Invariant: buf_valid and rd_inflight are never both 1; assert this in the bench.
- Peak throughput is 1 word/cycle with no CPU traffic. Each CPU read steals one read slot; each CPU write steals one write slot.
- CPU read data: cpu_rd_d <= cpu_ren. When cpu_rd_d=1, cpu_rdata = mem_rdata and the hold register loads it; otherwise cpu_rdata = hold register. DMA reads never disturb cpu_rdata.
- Copy order: always ascending. An overlap with src < dst < src+len gives replicate semantics, not memmove.
- Pointers do not wrap, because the range check bounds them below IO_START. A DMA access never reaches PS2_REG, so it never produces a ps2 side effect.
- A start asserted while busy has no effect (no err).

Decomposition:
- Shared package mem_map_pkg:
  - constants TILEMAP_START 16'hC000, FRAMEBUFFER_START 16'hE000, IO_START 16'hF000, PS2_REG 16'hF000
  - DMA state enum {IDLE, RUN}
  - The memory module is to import the same constants.
- One sub-module, dma_skid_buf: the 1-entry buffer plus the write-select mux.

Test Plan:
- src=0x0100, dst=0xE000, len=4, no CPU traffic: RAM words A,B,C,D written to 0xE000..0xE003 on 4 consecutive cycles; done 6 cycles after start; busy high for 5 cycles.
- Same copy with cpu_wen held for 3 cycles during RUN: buffer captures one word; all 4 words land correctly; CPU writes are committed untouched; done is delayed by 3 cycles.
- cpu_ren on alternating cycles during a len=8 copy: every cpu_rdata matches its own address (hold value stable across DMA reads); copy completes correctly.
- start with src=0xEFFE, len=3 (sum 0xF001): err pulse, busy stays 0, no mem_ren/mem_wen from the DMA; a separate len=0 start gives a done pulse only.
- rst_n low mid-copy at word 2 of 6: all outputs 0 immediately; no further DMA writes; a new start after release copies correctly.
- start pulsed during busy: ignored, with no err or restart.
